// File: rtl/alu_executor.sv
// -----------------------------------------------------------------------------
// alu_executor
//
// Registered single-issue ALU with a start/ready request handshake and a
// one-cycle done pulse. AND/OR/NOR/ADD/SUB/LUI/JAL finish one cycle after
// acceptance. SLL/SRL are optional: when built with the macro ALU_SHIFT_EN
// they run on a bit-serial shifter (one bit per cycle) and finish shamt+1
// cycles after acceptance. Without that macro, the shift codes are reported
// as unsupported and the block is always ready.
//
// Parameters
//   ERR_RESULT    value placed on ALUResult for an unsupported ALUOperation
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-low
//   start         request qualifier, accepted when start && ready
//   ALUOperation  4-bit operation code from the ALU control unit
//   A, B          32-bit operands (A = rs or PC, B = rt or immediate)
//   shamt         shift amount for SLL/SRL
//   ready         high when a new request can be accepted
//   done          single-cycle pulse: ALUResult/Zero/error are valid
//   ALUResult     registered result, held between done pulses
//   Zero          registered (ALUResult == 0)
//   error         registered unsupported-operation flag
// -----------------------------------------------------------------------------
module alu_executor #(
    parameter logic [31:0] ERR_RESULT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  ALUOperation,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  shamt,
    output logic        ready,
    output logic        done,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic        error
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_JAL = 4'b0110;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
`endif

    // Result to be written into the output registers on the cycle finish is high.
    logic        finish;
    logic [31:0] finish_result;
    logic        finish_error;

    // Single-cycle decode of the operation presented on the inputs.
    logic [31:0] op_result;
    logic        op_error;
`ifdef ALU_SHIFT_EN
    logic        op_is_shift;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        op_result   = ERR_RESULT;
        op_error    = 1'b1;
`ifdef ALU_SHIFT_EN
        op_is_shift = 1'b0;
`endif
        case (ALUOperation)
            OP_AND: begin op_result = A & B;             op_error = 1'b0; end
            OP_OR:  begin op_result = A | B;             op_error = 1'b0; end
            OP_NOR: begin op_result = ~(A | B);          op_error = 1'b0; end
            OP_ADD: begin op_result = A + B;             op_error = 1'b0; end
            OP_SUB: begin op_result = A - B;             op_error = 1'b0; end
            OP_LUI: begin op_result = {B[15:0], 16'h0};  op_error = 1'b0; end
            OP_JAL: begin op_result = A + 32'd8;         op_error = 1'b0; end
`ifdef ALU_SHIFT_EN
            // A zero-length shift finishes immediately with B unchanged;
            // longer shifts are handed to the serial shifter below.
            OP_SLL,
            OP_SRL: begin
                op_result   = B;
                op_error    = 1'b0;
                op_is_shift = 1'b1;
            end
`endif
            default: ;
        endcase
    end

`ifdef ALU_SHIFT_EN
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [31:0] work_shifted;
    logic [4:0]  count_q, count_d;
    logic        shift_left_q, shift_left_d;

    assign work_shifted = shift_left_q ? (work_q << 1) : (work_q >> 1);
    assign ready        = (state_q == IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge.
        if (!reset) begin
            state_q      <= IDLE;
            work_q       <= '0;
            count_q      <= '0;
            shift_left_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            count_q      <= count_d;
            shift_left_q <= shift_left_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        count_d       = count_q;
        shift_left_d  = shift_left_q;
        finish        = 1'b0;
        finish_result = op_result;
        finish_error  = op_error;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_is_shift && (shamt != 5'd0)) begin
                        // Operands are captured here; later input changes
                        // cannot disturb the in-flight shift.
                        state_d      = SHIFT;
                        work_d       = B;
                        count_d      = shamt;
                        shift_left_d = (ALUOperation == OP_SLL);
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d        = work_shifted;
                count_d       = count_q - 5'd1;
                finish_result = work_shifted;
                finish_error  = 1'b0;
                if (count_q == 5'd1) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
        endcase
    end
`else
    // No multi-cycle path exists, so every request completes in one cycle.
    logic unused_shamt;
    assign unused_shamt  = ^shamt;
    assign ready         = 1'b1;
    assign finish        = start;
    assign finish_result = op_result;
    assign finish_error  = op_error;
`endif

    // Output registers: load on completion, otherwise hold the last result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            error     <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                ALUResult <= finish_result;
                Zero      <= (finish_result == 32'd0);
                error     <= finish_error;
            end
        end
    end

endmodule

// File: tb/tb_alu_executor.sv
// -----------------------------------------------------------------------------
// tb_alu_executor
//
// Directed self-checking bench for alu_executor. Inputs change 1 ns after a
// rising edge and outputs are sampled 1 ns after the next rising edge.
// Shift-pipeline scenarios are compiled in only when ALU_SHIFT_EN is defined;
// otherwise the shift codes are checked as unsupported.
// -----------------------------------------------------------------------------
module tb_alu_executor;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_JAL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic        ready;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        error;

    int checks   = 0;
    int failures = 0;

    // Packed view of the result outputs: {done, error, Zero, ALUResult}.
    logic [34:0] obs;
    assign obs = {done, error, Zero, ALUResult};

    always #5 clk = ~clk;

    alu_executor #(.ERR_RESULT(ERR)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .ready        (ready),
        .done         (done),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .error        (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        start        = st;
        ALUOperation = op;
        A            = a;
        B            = b;
        shamt        = sh;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 5'd0);   // start during reset is dropped
        tick();
        tick();
        checks++;
        if ({ready, obs} !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_state: got ready/done/err/zero/res=%h required %h",
                     {ready, obs}, {1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        end
        reset = 1'b1;
        drive(1'b0, OP_ADD, 32'd1, 32'd2, 5'd0);
        tick();
        checks++;
        if ({ready, obs} !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_release: got %h required %h",
                     {ready, obs}, {1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 32'h8000_0000}) begin
            failures++;
            $display("FAIL add_overflow: got %h required %h", obs, {1'b1, 1'b0, 1'b0, 32'h8000_0000});
        end
        // Idle cycle with changed inputs: done drops, outputs hold.
        drive(1'b0, OP_SUB, 32'h0, 32'h5, 5'd0);
        tick();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'h8000_0000}) begin
            failures++;
            $display("FAIL add_hold: got %h required %h", obs, {1'b0, 1'b0, 1'b0, 32'h8000_0000});
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, OP_SUB, 32'h1234_5678, 32'h1234_5678, 5'd0);
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL b2b_sub: got %h required %h", obs, {1'b1, 1'b0, 1'b1, 32'h0});
        end
        drive(1'b1, OP_NOR, 32'h0, 32'h0, 5'd0);
        tick();
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL b2b_nor: got %h required %h", obs, {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF});
        end
        drive(1'b0, OP_NOR, 32'h0, 32'h0, 5'd0);
        tick();
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL b2b_pulse_end: got %h required %h", obs, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_ops();
        logic [3:0]  ops [9] = '{OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SUB, OP_JAL, OP_JAL, OP_LUI};
        logic [31:0] av  [9] = '{32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0,
                                 32'h5, 32'hFFFF_FFFC, 32'h0040_0000, 32'hFFFF_FFFF};
        logic [31:0] bv  [9] = '{32'h0FF0_FFFF, 32'h0000_000F, 32'h0000_FFFF, 32'h1, 32'h1,
                                 32'h7, 32'h1234, 32'h0, 32'h1234_ABCD};
        logic [31:0] ev  [9] = '{32'h00F0_1234, 32'hF000_000F, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFE, 32'h0000_0004, 32'h0040_0008, 32'hABCD_0000};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ops[i], av[i], bv[i], 5'd3);
            tick();
            checks++;
            if (obs !== {1'b1, 1'b0, (ev[i] == 32'h0), ev[i]}) begin
                failures++;
                $display("FAIL op_vector_%0d: got %h required %h", i, obs,
                         {1'b1, 1'b0, (ev[i] == 32'h0), ev[i]});
            end
        end
        drive(1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
        tick();
    endtask

    task automatic test_unsupported();
        logic [3:0]  ops [4] = '{4'b1001, 4'b1111, OP_LUI, 4'b1010};
        logic        ee  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] ev  [4] = '{ERR, ERR, 32'hABCD_0000, ERR};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 32'h1, 32'h0000_ABCD, 5'd0);
            tick();
            checks++;
            if (obs !== {1'b1, ee[i], 1'b0, ev[i]}) begin
                failures++;
                $display("FAIL unsupported_%0d: got %h required %h", i, obs, {1'b1, ee[i], 1'b0, ev[i]});
            end
        end
        drive(1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
        tick();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, ERR}) begin
            failures++;
            $display("FAIL unsupported_hold: got %h required %h", obs, {1'b0, 1'b1, 1'b0, ERR});
        end
    endtask

`ifdef ALU_SHIFT_EN
    task automatic test_shift();
        logic [3:0]  ops [5] = '{OP_SRL, OP_SLL, OP_SRL, OP_SRL, OP_SLL};
        logic [31:0] bv  [5] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0000, 32'h0000_000F, 32'h0000_0001};
        logic [4:0]  sv  [5] = '{5'd0, 5'd1, 5'd4, 5'd4, 5'd31};
        logic [31:0] ev  [5] = '{32'h8000_0001, 32'h0000_0002, 32'h0800_0000, 32'h0, 32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], 32'h0, bv[i], sv[i]);
            for (int k = 1; k <= int'(sv[i]); k++) begin
                tick();
                checks++;
                if ({ready, done} !== 2'b00) begin
                    failures++;
                    $display("FAIL shift_%0d_busy_cycle_%0d: got ready/done=%b required 00", i, k, {ready, done});
                end
                // Requests while busy are ignored and operand changes do not leak in.
                drive(k[0], OP_ADD, 32'(k), 32'hFFFF_FFFF, 5'd5);
            end
            tick();
            checks++;
            if ({ready, obs} !== {1'b1, 1'b1, 1'b0, (ev[i] == 32'h0), ev[i]}) begin
                failures++;
                $display("FAIL shift_%0d_result: got %h required %h", i, {ready, obs},
                         {1'b1, 1'b1, 1'b0, (ev[i] == 32'h0), ev[i]});
            end
            drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0);
            tick();
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL shift_%0d_pulse_end: got done=%b required 0", i, done);
            end
        end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, OP_ADD, 32'h1, 32'h1, 5'd0);
        tick();
        drive(1'b1, OP_SRL, 32'h0, 32'h8000_0000, 5'd4);
        tick();
        checks++;
        if ({ready, obs} !== {1'b0, 1'b0, 1'b0, 1'b0, 32'h2}) begin
            failures++;
            $display("FAIL abort_busy: got %h required %h", {ready, obs}, {1'b0, 1'b0, 1'b0, 1'b0, 32'h2});
        end
        reset = 1'b0;
        drive(1'b1, OP_ADD, 32'h3, 32'h3, 5'd0);
        tick();
        reset = 1'b1;
        drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({ready, obs} !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h0}) begin
                failures++;
                $display("FAIL abort_after_reset_%0d: got %h required %h", k, {ready, obs},
                         {1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
            end
            tick();
        end
    endtask
`else
    task automatic test_shift_disabled();
        logic [3:0]  ops [2] = '{OP_SLL, OP_SRL};
        logic [31:0] bv  [2] = '{32'h0000_0001, 32'h8000_0000};
        logic [4:0]  sv  [2] = '{5'd3, 5'd4};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ops[i], 32'h0, bv[i], sv[i]);
            tick();
            checks++;
            if ({ready, obs} !== {1'b1, 1'b1, 1'b1, 1'b0, ERR}) begin
                failures++;
                $display("FAIL shift_disabled_%0d: got %h required %h", i, {ready, obs},
                         {1'b1, 1'b1, 1'b1, 1'b0, ERR});
            end
        end
        drive(1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL shift_disabled_pulse_end: got done=%b required 0", done);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        drive(1'b0, OP_AND, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_ops();
        test_unsupported();
`ifdef ALU_SHIFT_EN
        test_shift();
        test_reset_abort();
`else
        test_shift_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_executor.md
ALU_EXECUTOR -- requirements
Module: alu_executor

Interface
REQ-001 The block SHALL have parameter ERR_RESULT, default 32'h0000_0000, value loaded into ALUResult for an unsupported ALUOperation.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request qualifier; accepted when start && ready at a rising edge.
REQ-005 The block SHALL have port ALUOperation, input, 4, operation code from the ALU control unit.
REQ-006 The block SHALL have ports A and B, inputs, 32 each, operands (A = rs or PC, B = rt or immediate).
REQ-007 The block SHALL have port shamt, input, 5, shift amount for SLL/SRL.
REQ-008 The block SHALL have port ready, output, 1, high when a new request may be accepted.
REQ-009 The block SHALL have port done, output, 1, single-cycle pulse marking ALUResult/Zero/error valid.
REQ-010 The block SHALL have ports ALUResult (32), Zero (1) and error (1), all outputs, registered.

Function
REQ-011 Codes: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 LUI, 0110 JAL, 0111 SLL, 1000 SRL; all others unsupported.
REQ-012 Results: AND A&B; OR A|B; NOR ~(A|B); ADD A+B; SUB A-B; LUI {B[15:0],16'h0}; JAL A+32'd8; SLL B<<shamt; SRL B>>shamt (logical, zero fill).
REQ-013 All arithmetic SHALL be modulo 2^32; carry and overflow discarded, no exceptions raised.
REQ-014 Zero SHALL equal (ALUResult == 0) for the result presented with each done pulse.
REQ-015 FSM states SHALL be IDLE and SHIFT; ready = 1 exactly in IDLE.
REQ-016 IDLE, accepted non-shift op: result registered at that edge, done = 1 the following cycle, state stays IDLE (latency 1, throughput 1/cycle).
REQ-017 IDLE, accepted shift op with shamt = 0: behaves as REQ-016 with ALUResult = B.
REQ-018 IDLE, accepted shift op with shamt > 0: load B into working register and shamt into down-counter, go to SHIFT.
REQ-019 SHIFT: each cycle shift working register one bit in the requested direction and decrement counter; when counter reaches 1 the final shift is written to ALUResult, done pulses next cycle, state returns to IDLE (latency shamt+1 cycles from acceptance).
REQ-020 start is ignored while ready = 0; operands SHALL be captured at acceptance, later input changes have no effect on an in-flight op.
REQ-021 Unsupported code: ALUResult = ERR_RESULT, error = 1, done pulses with latency 1; error is 0 for every supported op.
REQ-022 ALUResult, Zero and error SHALL hold their last values between done pulses.
REQ-023 done SHALL be low in every cycle not covered by REQ-016, REQ-017, REQ-019, REQ-021.

Reset
REQ-024 With reset low at a rising edge: state IDLE, ready = 1, done = 0, ALUResult = 0, Zero = 1, error = 0, counter and working register cleared.
REQ-025 Reset asserted during SHIFT SHALL abort the op with no done pulse; a start in the same cycle as reset is dropped.

Configuration
REQ-026 Macro ALU_SHIFT_EN defined: SLL/SRL supported per REQ-017 to REQ-019.
REQ-027 ALU_SHIFT_EN undefined: SHIFT state, counter and working register absent; codes 0111/1000 treated as unsupported per REQ-021; ready constantly 1 outside reset.

Verification
REQ-028 ADD A=32'h7FFF_FFFF B=1 -> next cycle done=1, ALUResult=32'h8000_0000, Zero=0, error=0.
REQ-029 SUB A=B=32'h1234_5678 back-to-back with NOR A=0 B=0 -> done on two consecutive cycles, results 0 (Zero=1) then 32'hFFFF_FFFF (Zero=0).
REQ-030 SLL B=1 shamt=31 (ALU_SHIFT_EN) -> ready=0 for 31 cycles, start pulses ignored, done at cycle 32, ALUResult=32'h8000_0000.
REQ-031 SRL B=32'h8000_0000 shamt=4, reset low at cycle 2 -> no done, ready=1, ALUResult=0 after reset.
REQ-032 ALUOperation=4'b1001 -> done next cycle, error=1, ALUResult=ERR_RESULT; LUI B=32'h0000_ABCD -> 32'hABCD_0000, error=0.
REQ-033 Without ALU_SHIFT_EN, SLL B=1 shamt=3 -> done next cycle, error=1, ALUResult=ERR_RESULT.
